// File: rtl/sd_spi_xfer.sv
// sd_spi_xfer: SPI mode-0 byte exchanger for SD cards with a slow/fast SCLK divider.
// Receive-side CRC16-CCITT is built only when SD_SPI_CRC16_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; sclk low, mosi high
// LOW   | sclk low half-period; mosi holds the current tx bit
// HIGH  | sclk high half-period; miso already captured
// DONE  | publish received byte and pulse done
module sd_spi_xfer #(
   parameter int unsigned DIV_SLOW = 63,
   parameter int unsigned DIV_FAST = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  din,
   input  logic        slow,
   input  logic        cs_assert,
   input  logic        crc_clr,
   input  logic        miso,
   output logic [7:0]  dout,
   output logic        busy,
   output logic        done,
   output logic [15:0] crc,
   output logic        mosi,
   output logic        sclk,
   output logic        ss
);

   localparam int CW = 16;
   localparam logic [CW-1:0] DIV_SLOW_C = CW'(DIV_SLOW);
   localparam logic [CW-1:0] DIV_FAST_C = CW'(DIV_FAST);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] div_q, div_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    tx_q, tx_d;
   logic [7:0]    rx_q, rx_d;
   logic [7:0]    dout_q, dout_d;
   logic          done_q, done_d;
   logic          sclk_q, sclk_d;
   logic          mosi_q, mosi_d;
   logic          ss_q;
   logic          sample;
   logic [CW-1:0] div_raw;
   logic [CW-1:0] div_sel;

   // A zero divider would never let the half-period counter expire, so clamp to 1.
   always_comb begin
      div_raw = slow ? DIV_SLOW_C : DIV_FAST_C;
      div_sel = (div_raw == '0) ? {{(CW-1){1'b0}}, 1'b1} : div_raw;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b1;
         ss_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         ss_q    <= ~cs_assert;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      sample  = 1'b0;
      unique case (state_q)
         IDLE: begin
            sclk_d = 1'b0;
            mosi_d = 1'b1;
            if (start) begin
               div_d   = div_sel;
               tx_d    = din;
               mosi_d  = din[7];
               bit_d   = '0;
               cnt_d   = div_sel - {{(CW-1){1'b0}}, 1'b1};
               state_d = LOW;
            end
         end
         LOW: begin
            if (cnt_q == '0) begin
               state_d = HIGH;
               sclk_d  = 1'b1;
               rx_d    = {rx_q[6:0], miso};
               sample  = 1'b1;
               cnt_d   = div_q - {{(CW-1){1'b0}}, 1'b1};
            end else begin
               cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         HIGH: begin
            if (cnt_q == '0) begin
               sclk_d = 1'b0;
               cnt_d  = div_q - {{(CW-1){1'b0}}, 1'b1};
               if (bit_q == 3'd7) begin
                  state_d = DONE;
                  mosi_d  = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  tx_d    = {tx_q[6:0], 1'b0};
                  mosi_d  = tx_q[6];
                  state_d = LOW;
               end
            end else begin
               cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            dout_d  = rx_q;
            done_d  = 1'b1;
            mosi_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef SD_SPI_CRC16_EN
   logic [15:0] crc_q, crc_d;
   logic        crc_fb;

   // CRC16-CCITT, MSB first, one received bit per miso sample.
   always_comb begin
      crc_fb = crc_q[15] ^ miso;
      crc_d  = crc_q;
      if (crc_clr) begin
         crc_d = '0;
      end else if (sample) begin
         crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;
`else
   logic unused_crc_inputs;
   assign unused_crc_inputs = crc_clr ^ sample;
   assign crc = 16'h0000;
`endif

   assign dout = dout_q;
   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign mosi = mosi_q;
   assign sclk = sclk_q;
   assign ss   = ss_q;

endmodule

// File: tb/tb_sd_spi_xfer.sv
// Directed bench for sd_spi_xfer: vector table of byte exchanges plus reset-abort and CRC sequences.
module tb_sd_spi_xfer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        slow = 1'b0;
   logic        cs_assert = 1'b0;
   logic        crc_clr = 1'b0;
   logic        miso;
   logic [7:0]  dout;
   logic        busy;
   logic        done;
   logic [15:0] crc;
   logic        mosi;
   logic        sclk;
   logic        ss;

   logic        loopb = 1'b1;
   logic        miso_r = 1'b1;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [7:0] din;
      logic       slow;
      logic       loopb;
      logic [7:0] card;
      int         restart_at;
      int         cs_at;
      logic [7:0] exp_dout;
      int         exp_lat;
      int         exp_hi;
   } vec_t;

   vec_t vecs[8];

   assign miso = loopb ? mosi : miso_r;

   sd_spi_xfer #(.DIV_SLOW(63), .DIV_FAST(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .din       (din),
      .slow      (slow),
      .cs_assert (cs_assert),
      .crc_clr   (crc_clr),
      .miso      (miso),
      .dout      (dout),
      .busy      (busy),
      .done      (done),
      .crc       (crc),
      .mosi      (mosi),
      .sclk      (sclk),
      .ss        (ss)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Runs one exchange; the card model shifts its byte out on each sclk fall.
   task automatic run_vec(input vec_t v, input string tag);
      int         cyc, done_cyc, rises, hi_run, hi_min, hi_max, done_cnt, idx;
      logic       sclk_prev;
      logic [7:0] card;
      card      = v.card;
      idx       = 0;
      loopb     = v.loopb;
      miso_r    = card[7];
      cs_assert = 1'b1;
      @(negedge clk);
      start = 1'b1;
      din   = v.din;
      slow  = v.slow;
      cyc = 0; done_cyc = -1; rises = 0; hi_run = 0; hi_min = 9999; hi_max = 0;
      done_cnt = 0; sclk_prev = 1'b0;
      while (cyc < 1200 && (done_cyc < 0 || cyc < done_cyc + 4)) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start = 1'b0;
         if (v.restart_at != 0 && cyc == v.restart_at) begin
            start = 1'b1;
            din   = ~v.din;
            slow  = 1'b1;
         end else if (v.restart_at != 0 && cyc == v.restart_at + 1) begin
            start = 1'b0;
         end
         if (sclk && !sclk_prev) rises++;
         if (sclk) hi_run++;
         if (!sclk && sclk_prev) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            hi_run = 0;
            idx++;
            if (idx < 8) miso_r = card[7-idx];
         end
         sclk_prev = sclk;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (v.cs_at != 0) begin
            if (cyc == v.cs_at) begin
               cs_assert = 1'b0;
            end else if (cyc == v.cs_at + 1) begin
               check({tag, ".ss_deassert"}, 32'(ss), 32'd1);
               cs_assert = 1'b1;
            end else if (cyc == v.cs_at + 2) begin
               check({tag, ".ss_reassert"}, 32'(ss), 32'd0);
            end
         end
      end
      start = 1'b0;
      check({tag, ".dout"}, 32'(dout), 32'(v.exp_dout));
      check({tag, ".latency"}, 32'(done_cyc - 1), 32'(v.exp_lat));
      check({tag, ".sclk_rises"}, 32'(rises), 32'd8);
      check({tag, ".sclk_hi_min"}, 32'(hi_min), 32'(v.exp_hi));
      check({tag, ".sclk_hi_max"}, 32'(hi_max), 32'(v.exp_hi));
      check({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
      check({tag, ".busy_after"}, 32'(busy), 32'd0);
      check({tag, ".mosi_idle"}, 32'(mosi), 32'd1);
   endtask

   initial begin
      int         r;
      int         guard;
      int         dcnt;
      logic       p;
      vec_t       cv;
      logic [7:0] b;

      // din, slow, loopback, card byte, restart cycle, cs toggle cycle, dout, latency, sclk high width
      vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'h00, 0,  0, 8'hA5, 17,   1};
      vecs[1] = '{8'h00, 1'b0, 1'b1, 8'h00, 0,  0, 8'h00, 17,   1};
      vecs[2] = '{8'hFF, 1'b0, 1'b0, 8'h5A, 0,  0, 8'h5A, 17,   1};
      vecs[3] = '{8'h3C, 1'b0, 1'b1, 8'h00, 5,  0, 8'h3C, 17,   1};
      vecs[4] = '{8'hC3, 1'b0, 1'b1, 8'h00, 17, 0, 8'hC3, 17,   1};
      vecs[5] = '{8'h96, 1'b0, 1'b1, 8'h00, 0,  6, 8'h96, 17,   1};
      vecs[6] = '{8'h12, 1'b1, 1'b0, 8'h01, 0,  0, 8'h01, 1009, 63};
      vecs[7] = '{8'h7E, 1'b0, 1'b0, 8'h81, 0,  0, 8'h81, 17,   1};

      reset = 1'b0;
      cs_assert = 1'b1;
      repeat (3) @(negedge clk);
      check("rst.sclk", 32'(sclk), 32'd0);
      check("rst.mosi", 32'(mosi), 32'd1);
      check("rst.ss", 32'(ss), 32'd1);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.dout", 32'(dout), 32'h00);
      check("rst.crc", 32'(crc), 32'h0000);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Abort an exchange at the 4th sclk rising edge.
      loopb = 1'b1;
      din = 8'h00;
      cs_assert = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      r = 0; guard = 0; p = sclk;
      while (r < 4 && guard < 100) begin
         @(negedge clk);
         guard++;
         if (sclk && !p) r++;
         p = sclk;
      end
      check("abort.reached_edge4", 32'(r), 32'd4);
      check("abort.mosi_before", 32'(mosi), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("abort.sclk", 32'(sclk), 32'd0);
      check("abort.mosi", 32'(mosi), 32'd1);
      check("abort.ss", 32'(ss), 32'd1);
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.done", 32'(done), 32'd0);
      check("abort.dout", 32'(dout), 32'h00);
      reset = 1'b1;
      dcnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("abort.no_done", 32'(dcnt), 32'd0);
      check("abort.dout_held", 32'(dout), 32'h00);
      check("abort.idle", 32'(busy), 32'd0);

`ifdef SD_SPI_CRC16_EN
      @(negedge clk);
      crc_clr = 1'b1;
      @(negedge clk);
      crc_clr = 1'b0;
      check("crc.clear", 32'(crc), 32'h0000);
      for (int i = 0; i < 9; i++) begin
         b = 8'h31 + 8'(i);
         cv = '{8'hFF, 1'b0, 1'b0, b, 0, 0, b, 17, 1};
         run_vec(cv, $sformatf("crc_msg%0d", i));
      end
      check("crc.check_value", 32'(crc), 32'h31C3);
      cv = '{8'hFF, 1'b0, 1'b0, 8'h31, 0, 0, 8'h31, 17, 1};
      run_vec(cv, "crc_tail_hi");
      cv = '{8'hFF, 1'b0, 1'b0, 8'hC3, 0, 0, 8'hC3, 17, 1};
      run_vec(cv, "crc_tail_lo");
      check("crc.residue", 32'(crc), 32'h0000);
`else
      cv = '{8'hFF, 1'b0, 1'b0, 8'h5A, 0, 0, 8'h5A, 17, 1};
      run_vec(cv, "nocrc");
      check("nocrc.crc_tied", 32'(crc), 32'h0000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
